intersection_queue_model: RTL and testbench

Closed-loop intersection model that sits on the sensor side of the 3-street traffic light controller. It consumes the five light outputs and per-lane car-arrival pulses, and keeps a saturating car queue per lane. It drives the five traffic sensors back into the controller and checks the light outputs for safety and sequencing violations. It is synthesizable and serves both as the bench's traffic generator back-end and as an on-chip safety monitor.

---
 rtl/light_package.sv | 45 ++++
 rtl/intersection_queue_model_lane_queue.sv | 74 +++++++
 rtl/intersection_queue_model.sv | 121 ++++++++++++
 tb/tb_intersection_queue_model.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/light_package.sv
`default_nettype none
// ============================================================================
// Module   : light_package
// Purpose  : Shared types for the 3-street traffic light system: light colors,
//            lane indices and the five legal simultaneous-lane groups.
// Contents : colors, lane_e, NUM_LANES, GRP_* masks, set_is_legal()
// Revision : 1.0 - initial release
// ============================================================================
package light_package;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } colors;

   typedef enum logic [2:0] {
      E_STR  = 3'd0,
      W_STR  = 3'd1,
      E_LEFT = 3'd2,
      W_LEFT = 3'd3,
      NS     = 3'd4
   } lane_e;

   localparam int NUM_LANES = 5;

   // Lane masks, bit position = lane_e value
   localparam logic [4:0] GRP_EW_STR   = 5'b00011;
   localparam logic [4:0] GRP_E_STR_LT = 5'b00101;
   localparam logic [4:0] GRP_W_STR_LT = 5'b01010;
   localparam logic [4:0] GRP_EW_LEFT  = 5'b01100;
   localparam logic [4:0] GRP_NS       = 5'b10000;

   // A set of non-red lanes is legal when empty or wholly inside one group
   function automatic logic set_is_legal(input logic [4:0] act);
      return (act == 5'b0)
          || ((act & ~GRP_EW_STR)   == 5'b0)
          || ((act & ~GRP_E_STR_LT) == 5'b0)
          || ((act & ~GRP_W_STR_LT) == 5'b0)
          || ((act & ~GRP_EW_LEFT)  == 5'b0)
          || ((act & ~GRP_NS)       == 5'b0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/intersection_queue_model_lane_queue.sv
`default_nettype none
// ============================================================================
// Module   : lane_queue
// Purpose  : One lane of the intersection model: saturating car queue plus
//            light-history tracking for sequence checking.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            light, arrive       - current lane light, car arrival pulse
//            q, sensor           - queue depth, queue-nonzero sensor
//            dep                 - a car departs this cycle
//            overflow            - arrival dropped this cycle (queue full)
//            left_yellow         - light left yellow this cycle
//            seq_viol            - illegal transition / yellow length this cycle
// Revision : 1.0 - initial release
// ============================================================================
module lane_queue
   import light_package::*;
#(
   parameter int QW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  colors         light,
   input  logic          arrive,
   output logic [QW-1:0] q,
   output logic          sensor,
   output logic          dep,
   output logic          overflow,
   output logic          left_yellow,
   output logic          seq_viol
);

   localparam logic [QW-1:0] Q_MAX = '1;

   colors       prev_light;
   logic [1:0]  ycnt;        // consecutive yellow cycles up to previous cycle (saturates)
   logic        was_y;
   logic        is_y;

   always_comb begin
      dep         = (light == GREEN) && (q != '0);
      overflow    = arrive && !dep && (q == Q_MAX);
      was_y       = (prev_light == YELLOW);
      is_y        = (light == YELLOW);
      left_yellow = was_y && !is_y;
      seq_viol    = ((prev_light == RED)   && is_y)
                 || (was_y                 && (light == GREEN))
                 || ((prev_light == GREEN) && (light == RED))
                 || (was_y && is_y && (ycnt >= 2'd2))   // third yellow cycle
                 || (left_yellow && (ycnt == 2'd1));    // yellow lasted one cycle
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q          <= '0;
         prev_light <= RED;
         ycnt       <= 2'd0;
      end else begin
         // arrival with departure leaves q unchanged
         if (arrive && !dep && (q != Q_MAX))
            q <= q + 1'b1;
         else if (dep && !arrive)
            q <= q - 1'b1;
         prev_light <= light;
         if (is_y)
            ycnt <= (ycnt == 2'd3) ? 2'd3 : ycnt + 2'd1;
         else
            ycnt <= 2'd0;
      end
   end

   assign sensor = (q != '0);

endmodule
`default_nettype wire

// File: rtl/intersection_queue_model.sv
`default_nettype none
// ============================================================================
// Module   : intersection_queue_model
// Purpose  : Closed-loop intersection model and safety monitor for the
//            3-street traffic light controller. Keeps a car queue per lane,
//            feeds sensors back, and flags conflicting or mis-sequenced lights.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            *_light                    - lights from the controller
//            *_arrive                   - per-lane car arrival pulses
//            *_sensor                   - per-lane queue-nonzero sensors
//            q_*                        - per-lane queue depths
//            departed_total             - cars departed since reset (wraps)
//            conflict_err/seq_err/overflow_err - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module intersection_queue_model
   import light_package::*;
#(
   parameter int QW = 4,
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  colors         e_str_light,
   input  colors         w_str_light,
   input  colors         e_left_light,
   input  colors         w_left_light,
   input  colors         ns_light,
   input  logic          e_str_arrive,
   input  logic          w_str_arrive,
   input  logic          e_left_arrive,
   input  logic          w_left_arrive,
   input  logic          ns_arrive,
   output logic          e_str_sensor,
   output logic          w_str_sensor,
   output logic          e_left_sensor,
   output logic          w_left_sensor,
   output logic          ns_sensor,
   output logic [QW-1:0] q_e_str,
   output logic [QW-1:0] q_w_str,
   output logic [QW-1:0] q_e_left,
   output logic [QW-1:0] q_w_left,
   output logic [QW-1:0] q_ns,
   output logic [TW-1:0] departed_total,
   output logic          conflict_err,
   output logic          seq_err,
   output logic          overflow_err
);

   colors           light_v [NUM_LANES];
   logic [4:0]      arrive_v;
   logic [QW-1:0]   q_v     [NUM_LANES];
   logic [4:0]      sensor_v;
   logic [4:0]      dep_v;
   logic [4:0]      ovf_v;
   logic [4:0]      left_y_v;
   logic [4:0]      seq_v;
   logic [4:0]      active_v;
   logic [4:0]      green_v;
   logic [2:0]      dep_count;
   logic            conflict_now;
   logic            gap_viol;

   assign light_v[E_STR]  = e_str_light;
   assign light_v[W_STR]  = w_str_light;
   assign light_v[E_LEFT] = e_left_light;
   assign light_v[W_LEFT] = w_left_light;
   assign light_v[NS]     = ns_light;
   assign arrive_v = {ns_arrive, w_left_arrive, e_left_arrive, w_str_arrive, e_str_arrive};

   generate
      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
         lane_queue #(.QW(QW)) u_lane (
            .clk         (clk),
            .reset       (reset),
            .light       (light_v[i]),
            .arrive      (arrive_v[i]),
            .q           (q_v[i]),
            .sensor      (sensor_v[i]),
            .dep         (dep_v[i]),
            .overflow    (ovf_v[i]),
            .left_yellow (left_y_v[i]),
            .seq_viol    (seq_v[i])
         );
         assign active_v[i] = (light_v[i] != RED);
         assign green_v[i]  = (light_v[i] == GREEN);
      end
   endgenerate

   assign {ns_sensor, w_left_sensor, e_left_sensor, w_str_sensor, e_str_sensor} = sensor_v;
   assign q_e_str  = q_v[E_STR];
   assign q_w_str  = q_v[W_STR];
   assign q_e_left = q_v[E_LEFT];
   assign q_w_left = q_v[W_LEFT];
   assign q_ns     = q_v[NS];

   always_comb begin
      dep_count = 3'd0;
      for (int i = 0; i < NUM_LANES; i++)
         dep_count = dep_count + {2'b00, dep_v[i]};
      conflict_now = !set_is_legal(active_v);
      // the cycle after any lane's yellow ends must be green-free
      gap_viol     = (|left_y_v) && (|green_v);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         departed_total <= '0;
         conflict_err   <= 1'b0;
         seq_err        <= 1'b0;
         overflow_err   <= 1'b0;
      end else begin
         departed_total <= departed_total + TW'(dep_count);
         conflict_err   <= conflict_err | conflict_now;
         seq_err        <= seq_err | (|seq_v) | gap_viol;
         overflow_err   <= overflow_err | (|ovf_v);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_intersection_queue_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_queue_model
// Purpose  : Self-checking scoreboard bench for intersection_queue_model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_queue_model;
   import light_package::*;

   localparam int QMAX = 15;

   typedef struct packed {
      logic [4:0][3:0] q;
      logic [15:0]     dt;
      logic            c;
      logic            s;
      logic            o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   colors       lt [5];
   logic [4:0]  arr = 5'b0;

   logic [4:0]  sens;
   logic [3:0]  dq [5];
   logic [15:0] dt;
   logic        c_err, s_err, o_err;

   int li [5];
   exp_t sbq [$];
   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int mq [5];
   int yrun [5];
   int prevl [5];
   int mdep;
   bit mc, ms, mo;
   int grp [5] = '{5'b00011, 5'b00101, 5'b01010, 5'b01100, 5'b10000};

   always #5 clk = ~clk;

   intersection_queue_model #(.QW(4), .TW(16)) dut (
      .clk(clk), .reset(rst),
      .e_str_light(lt[0]), .w_str_light(lt[1]), .e_left_light(lt[2]),
      .w_left_light(lt[3]), .ns_light(lt[4]),
      .e_str_arrive(arr[0]), .w_str_arrive(arr[1]), .e_left_arrive(arr[2]),
      .w_left_arrive(arr[3]), .ns_arrive(arr[4]),
      .e_str_sensor(sens[0]), .w_str_sensor(sens[1]), .e_left_sensor(sens[2]),
      .w_left_sensor(sens[3]), .ns_sensor(sens[4]),
      .q_e_str(dq[0]), .q_w_str(dq[1]), .q_e_left(dq[2]), .q_w_left(dq[3]), .q_ns(dq[4]),
      .departed_total(dt), .conflict_err(c_err), .seq_err(s_err), .overflow_err(o_err)
   );

   // Advance the reference model over one input cycle and queue the expected state.
   task automatic apply();
      exp_t e;
      bit   left_any, green_any, legal;
      for (int i = 0; i < 5; i++) lt[i] = colors'(li[i]);
      if (rst) begin
         for (int i = 0; i < 5; i++) begin mq[i] = 0; yrun[i] = 0; prevl[i] = 0; end
         mdep = 0; mc = 0; ms = 0; mo = 0;
      end else begin
         // conflict: every non-red lane must belong to one common group
         legal = 1'b1;
         begin
            bit any_act;
            bit fits;
            any_act = 0;
            for (int i = 0; i < 5; i++) if (li[i] != 0) any_act = 1;
            if (any_act) begin
               legal = 0;
               for (int g = 0; g < 5; g++) begin
                  fits = 1;
                  for (int i = 0; i < 5; i++)
                     if (li[i] != 0 && !grp[g][i]) fits = 0;
                  if (fits) legal = 1;
               end
            end
         end
         if (!legal) mc = 1;
         left_any = 0; green_any = 0;
         for (int i = 0; i < 5; i++) begin
            int c, p;
            bit d;
            c = li[i]; p = prevl[i];
            if ((p == 0 && c == 1) || (p == 1 && c == 2) || (p == 2 && c == 0)) ms = 1;
            if (c == 1 && yrun[i] + 1 > 2) ms = 1;            // yellow too long
            if (p == 1 && c != 1) begin
               left_any = 1;
               if (yrun[i] != 2) ms = 1;                       // yellow run ended early
            end
            if (c == 2) green_any = 1;
            yrun[i] = (c == 1) ? yrun[i] + 1 : 0;
            prevl[i] = c;
            d = (c == 2) && (mq[i] > 0);
            if (arr[i] && !d) begin
               if (mq[i] == QMAX) mo = 1; else mq[i]++;
            end else if (d && !arr[i]) mq[i]--;
            if (d) mdep = (mdep + 1) % 65536;
         end
         if (left_any && green_any) ms = 1;
      end
      for (int i = 0; i < 5; i++) e.q[i] = 4'(mq[i]);
      e.dt = 16'(mdep); e.c = mc; e.s = ms; e.o = mo;
      sbq.push_back(e);
   endtask

   task automatic cyc(input int es, ws, el, wl, ns, input logic [4:0] a, input bit r = 0);
      @(posedge clk); #2;
      li[0] = es; li[1] = ws; li[2] = el; li[3] = wl; li[4] = ns;
      arr = a; rst = r;
      apply();
   endtask

   // one random-phase cycle: lanes in mask show col, others red; rare fault injection
   task automatic rcyc(input int mask, input int col);
      @(posedge clk); #2;
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         li[i] = mask[i] ? col : 0;
         arr[i] = ($urandom_range(0, 99) < 30);
      end
      if ($urandom_range(0, 99) < 3)
         for (int i = 0; i < 5; i++) li[i] = $urandom_range(0, 2);
      apply();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // monitor: compares DUT state against each queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int i = 0; i < 5; i++) begin
               chk($sformatf("q[%0d]", i), int'(dq[i]), int'(e.q[i]));
               chk($sformatf("sensor[%0d]", i), int'(sens[i]), int'(e.q[i] != 0));
            end
            chk("departed_total", int'(dt), int'(e.dt));
            chk("conflict_err", int'(c_err), int'(e.c));
            chk("seq_err", int'(s_err), int'(e.s));
            chk("overflow_err", int'(o_err), int'(e.o));
         end
      end
   end

   initial begin
      for (int i = 0; i < 5; i++) begin li[i] = 0; lt[i] = RED; end
      // reset, then 3 arrivals on e_str
      cyc(0,0,0,0,0, 5'b0, 1); cyc(0,0,0,0,0, 5'b0, 1);
      repeat (3) cyc(0,0,0,0,0, 5'b00001);
      cyc(0,0,0,0,0, 5'b0);
      // ns: two cars, green 4 cycles, then yellow 2, red 2
      repeat (2) cyc(0,0,0,0,0, 5'b10000);
      repeat (4) cyc(0,0,0,0,2, 5'b0);
      repeat (2) cyc(0,0,0,0,1, 5'b0);
      repeat (2) cyc(0,0,0,0,0, 5'b0);
      // w_left saturation, then arrival+green at full
      repeat (16) cyc(0,0,0,0,0, 5'b01000);
      cyc(0,0,0,2,0, 5'b01000);
      repeat (2) cyc(0,0,0,1,0, 5'b0);
      cyc(0,0,0,0,0, 5'b0);
      // conflicting greens
      cyc(0,0,0,0,0, 5'b0, 1);
      cyc(0,2,2,0,0, 5'b0);
      cyc(0,0,0,0,0, 5'b0, 1);
      // legal e_str + e_left green
      repeat (2) cyc(2,0,2,0,0, 5'b0);
      repeat (2) cyc(1,0,1,0,0, 5'b0);
      cyc(0,0,0,0,0, 5'b0);
      // short yellow
      cyc(0,0,0,0,0, 5'b0, 1);
      cyc(0,0,0,0,2, 5'b0); cyc(0,0,0,0,1, 5'b0); cyc(0,0,0,0,0, 5'b0);
      // clean sequence
      cyc(0,0,0,0,0, 5'b0, 1);
      cyc(0,0,0,0,2, 5'b0); repeat (2) cyc(0,0,0,0,1, 5'b0); repeat (2) cyc(0,0,0,0,0, 5'b0);
      // no all-red gap
      cyc(0,0,0,0,2, 5'b0); repeat (2) cyc(0,0,0,0,1, 5'b0);
      repeat (2) cyc(2,0,0,0,0, 5'b00001);
      // reset mid-green, then continue legally
      cyc(2,0,0,0,0, 5'b00001, 1);
      repeat (2) cyc(2,0,0,0,0, 5'b0);
      repeat (2) cyc(1,0,0,0,0, 5'b0);
      cyc(0,0,0,0,0, 5'b0);
      // randomized legal traffic with occasional faults and resets
      cyc(0,0,0,0,0, 5'b0, 1);
      repeat (60) begin
         int g, gn, rn;
         g  = $urandom_range(0, 4);
         gn = $urandom_range(1, 6);
         rn = $urandom_range(1, 2);
         if ($urandom_range(0, 99) < 10) cyc(0,0,0,0,0, 5'b0, 1);
         repeat (gn) rcyc(grp[g], 2);
         repeat (2)  rcyc(grp[g], 1);
         repeat (rn) rcyc(0, 0);
      end
      repeat (2) @(posedge clk);
      #3;
      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d expected %0d", sbq.size(), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
